rx_byte_fifo: RTL and testbench

RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

---
 rtl/rx_byte_fifo_pkg.sv | 17 +
 rtl/rx_fifo_mem.sv | 49 ++++
 rtl/rx_byte_fifo.sv | 120 ++++++++++++
 tb/tb_rx_byte_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_byte_fifo_pkg.sv
// Shared UART receive-path constants.
// Holds the default byte width and FIFO depth used by the receiver and its
// byte FIFO, plus the pointer-width constant derived from the depth.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
package rx_byte_fifo_pkg;

    localparam int RX_DATA_WIDTH = 8;
    localparam int RX_FIFO_DEPTH = 8;

    // Pointer width for a FIFO of the given depth: address bits plus a wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int RX_PTR_W = ptr_width(RX_FIFO_DEPTH);

endpackage

// File: rtl/rx_fifo_mem.sv
// Storage array for the receive byte FIFO.
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// synchronous, registered read port. The array itself is never reset; only the
// read-data register is cleared so the FIFO output is defined out of reset.
// Ports:
//   CLK      - clock, rising edge
//   RST      - asynchronous active-low reset (read register only)
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write byte
//   rd_en    - read strobe; loads rd_data from rd_addr on the next edge
//   rd_addr  - read address
//   rd_data  - registered read byte, holds when rd_en=0
module rx_fifo_mem
    import rx_byte_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int DEPTH      = RX_FIFO_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // When read and write hit the same entry (full FIFO, simultaneous
    // operations) the old contents are returned, which is the oldest byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO sitting between the UART receiver and its consumer.
// Bytes arrive as one-cycle data_valid pulses; the consumer pulls them with
// rd_en and gets a registered byte one cycle later with a rd_valid pulse.
// Writes into a full FIFO without a simultaneous read are dropped and latch
// the sticky overflow flag.
// Ports:
//   CLK         - clock, rising edge
//   RST         - asynchronous active-low reset
//   wr_valid    - write strobe (receiver data_valid)
//   wr_data     - received byte
//   rd_en       - consumer read request
//   ovf_clr     - synchronous clear of overflow
//   rd_data     - registered read byte
//   rd_valid    - one-cycle pulse qualifying rd_data
//   empty       - occupancy is zero
//   full        - occupancy equals DEPTH
//   almost_full - occupancy at or above AFULL_LVL
//   count       - current occupancy
//   overflow    - sticky dropped-byte flag
// DEPTH must be a power of two (minimum 2); AFULL_LVL must be 1..DEPTH-1.
module rx_byte_fifo
    import rx_byte_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int DEPTH      = RX_FIFO_DEPTH,
    parameter int AFULL_LVL  = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_valid,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LVL);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_nxt;
    logic          wr_acc;
    logic          rd_acc;
    logic          ovf_set;

    // A full FIFO still takes a write when a read frees a slot the same cycle.
    // An empty FIFO never reads, so a simultaneous write does not fall through.
    assign wr_acc  = wr_valid & (~full | rd_en);
    assign rd_acc  = rd_en & ~empty;
    assign ovf_set = wr_valid & full & ~rd_en;

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    // Flags are registered from the next occupancy so they change in the
    // same cycle as count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_C;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE_C;
            end
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == DEPTH_C);
            almost_full <= (count_nxt >= AFULL_C);
            rd_valid    <= rd_acc;
            // A new drop takes priority over a clear in the same cycle.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo: a queue-based reference model checked
// against the DUT on every falling edge, plus directed literal expectations.
module tb_rx_byte_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic          CLK;
    logic          RST;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          ovf_clr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [3:0]    count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic          m_ovf;

    rx_byte_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFULL)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .ovf_clr     (ovf_clr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
    endtask

    // One clock of the FIFO behaviour, from the occupancy before the edge.
    task automatic model_step(input logic wv, input logic [DW-1:0] wd,
                              input logic re, input logic oc);
        int  n;
        bit  is_full;
        bit  do_wr;
        bit  do_rd;
        n       = q.size();
        is_full = (n == DEPTH);
        do_rd   = re && (n > 0);
        do_wr   = wv && (!is_full || re);
        if (wv && is_full && !re) m_ovf = 1'b1;
        else if (oc)              m_ovf = 1'b0;
        m_rd_valid = do_rd;
        if (do_rd) m_rd_data = q.pop_front();
        if (do_wr) q.push_back(wd);
    endtask

    task automatic cycle(input logic wv, input logic [DW-1:0] wd,
                         input logic re, input logic oc);
        @(negedge CLK);
        wr_valid = wv;
        wr_data  = wd;
        rd_en    = re;
        ovf_clr  = oc;
        @(posedge CLK);
        if (RST) model_step(wv, wd, re, oc);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Continuous comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("cmp_rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            check("cmp_rd_data",  32'(rd_data),  32'(m_rd_data));
            check("cmp_count",    32'(count),    32'(q.size()));
            check("cmp_empty",    32'(empty),    32'(q.size() == 0));
            check("cmp_full",     32'(full),     32'(q.size() == DEPTH));
            check("cmp_afull",    32'(almost_full), 32'(q.size() >= AFULL));
            check("cmp_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();
        #1 RST = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        chk_en = 1;
        @(posedge CLK);
        #3 RST = 1'b1;

        // Three bytes in, three out in order
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        check("w3_count", 32'(count), 32'd3);
        rd();
        check("r1_valid", 32'(rd_valid), 32'd1);
        check("r1_data",  32'(rd_data),  32'h11);
        rd();
        check("r2_data",  32'(rd_data),  32'h22);
        rd();
        check("r3_data",  32'(rd_data),  32'h33);
        check("r3_empty", 32'(empty),    32'd1);
        idle();
        check("hold_valid", 32'(rd_valid), 32'd0);
        check("hold_data",  32'(rd_data),  32'h33);

        // Fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            wr(8'(8'hA0 + i));
            if (i == 4) check("af_5th", 32'(almost_full), 32'd0);
            if (i == 5) check("af_6th", 32'(almost_full), 32'd1);
        end
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd8);
        check("fill_ovf",   32'(overflow), 32'd0);
        wr(8'hFF);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd8);
        rd();
        check("ovf_rd_data", 32'(rd_data), 32'hA0);
        check("ovf_sticky",  32'(overflow), 32'd1);
        wr(8'hB0);
        check("refull", 32'(full), 32'd1);
        // Drop and clear on the same cycle: drop wins
        cycle(1'b1, 8'hE1, 1'b0, 1'b1);
        check("set_wins", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous read and write while full
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        check("rw_full_data",  32'(rd_data),  32'hA1);
        check("rw_full_count", 32'(count),    32'd8);
        check("rw_full_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) rd();
        check("drain_last",  32'(rd_data), 32'h5A);
        check("drain_empty", 32'(empty),   32'd1);
        rd();
        check("rd_empty_valid", 32'(rd_valid), 32'd0);
        check("rd_empty_data",  32'(rd_data),  32'h5A);

        // Write/read pairs across pointer wrap
        for (int i = 0; i < 20; i++) begin
            wr(8'(8'h40 + i));
            check("pair_count1", 32'(count), 32'd1);
            rd();
            check("pair_data",   32'(rd_data), 32'(8'h40 + i));
            check("pair_count0", 32'(count), 32'd0);
        end

        // Read and write together while empty: no fall-through
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        check("nft_valid", 32'(rd_valid), 32'd0);
        check("nft_count", 32'(count),    32'd1);
        rd();
        check("nft_rd_valid", 32'(rd_valid), 32'd1);
        check("nft_rd_data",  32'(rd_data),  32'h3C);

        // Mid-operation asynchronous reset
        for (int i = 0; i < 8; i++) wr(8'(8'hC0 + i));
        wr(8'hFF);
        rd();
        rd();
        rd();
        check("pre_rst_count", 32'(count),    32'd5);
        check("pre_rst_ovf",   32'(overflow), 32'd1);
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
        #1 RST = 1'b0;
        model_reset();
        #1;
        check("arst_count", 32'(count),       32'd0);
        check("arst_empty", 32'(empty),       32'd1);
        check("arst_full",  32'(full),        32'd0);
        check("arst_af",    32'(almost_full), 32'd0);
        check("arst_ovf",   32'(overflow),    32'd0);
        check("arst_valid", 32'(rd_valid),    32'd0);
        check("arst_data",  32'(rd_data),     32'd0);
        @(posedge CLK);
        #3 RST = 1'b1;
        wr(8'h77);
        check("post_rst_count", 32'(count), 32'd1);
        rd();
        check("post_rst_valid", 32'(rd_valid), 32'd1);
        check("post_rst_data",  32'(rd_data),  32'h77);
        idle();
        idle();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
